// File: rtl/aucohl_pwm_gate_drv.sv
// Complementary high-side/low-side gate driver with programmable dead time
// and a filtered, latched fault trip that forces both drives off.
module aucohl_pwm_gate_drv #(
    parameter int DT_W    = 8,
    parameter int FLT_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt,
    input  logic            flt_in,
    input  logic            flt_pol,
    input  logic            flt_clr,
    output logic            hs_out,
    output logic            ls_out,
    output logic            flt_trip,
    output logic            flt_raw,
    output logic [2:0]      dbg_state_o
);

    localparam int FC_W = $clog2(FLT_LEN + 1);
    localparam logic [FC_W-1:0] FLT_MAX = FC_W'(FLT_LEN);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_DT_HI = 3'd1,
        S_HIGH  = 3'd2,
        S_DT_LO = 3'd3,
        S_LOW   = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Fault path: normalise polarity, synchronise, filter, latch.
    // ------------------------------------------------------------------
    logic            flt_act;
    logic            sync1_q, sync2_q;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            raw_q;
    logic            trip_q, trip_d;
    logic            trip_set;

    assign flt_act = flt_in ^ ~flt_pol;

    always_comb begin
        fcnt_d = '0;
        if (sync2_q) begin
            fcnt_d = (fcnt_q == FLT_MAX) ? fcnt_q : fcnt_q + FC_W'(1);
        end
    end

    assign trip_set = (fcnt_d == FLT_MAX);

    // Set dominates clear, and a clear is refused while the filtered fault is still up.
    always_comb begin
        trip_d = trip_q;
        if (trip_set) begin
            trip_d = 1'b1;
        end else if (flt_clr && !raw_q) begin
            trip_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fcnt_q  <= '0;
            raw_q   <= 1'b0;
            trip_q  <= 1'b0;
        end else begin
            sync1_q <= flt_act;
            sync2_q <= sync1_q;
            fcnt_q  <= fcnt_d;
            raw_q   <= trip_set;
            trip_q  <= trip_d;
        end
    end

    // ------------------------------------------------------------------
    // Drive FSM with registered outputs.
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [DT_W-1:0] dcnt_q;
    logic            hs_q, ls_q;
    logic            force_off;

    assign force_off = !en || trip_q || trip_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            dcnt_q  <= '0;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else if (force_off) begin
            state_q <= S_OFF;
            dcnt_q  <= '0;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            case (state_q)
                S_OFF: begin
                    // Start-up holds a full dt after the leaving edge.
                    dcnt_q  <= dt;
                    hs_q    <= 1'b0;
                    ls_q    <= 1'b0;
                    state_q <= pwm_in ? S_DT_HI : S_DT_LO;
                end
                S_LOW: begin
                    if (pwm_in) begin
                        ls_q <= 1'b0;
                        if (dt == '0) begin
                            hs_q    <= 1'b1;
                            state_q <= S_HIGH;
                        end else begin
                            dcnt_q  <= dt - DT_W'(1);
                            state_q <= S_DT_HI;
                        end
                    end
                end
                S_HIGH: begin
                    if (!pwm_in) begin
                        hs_q <= 1'b0;
                        if (dt == '0) begin
                            ls_q    <= 1'b1;
                            state_q <= S_LOW;
                        end else begin
                            dcnt_q  <= dt - DT_W'(1);
                            state_q <= S_DT_LO;
                        end
                    end
                end
                S_DT_HI: begin
                    if (!pwm_in) begin
                        dcnt_q  <= '0;
                        ls_q    <= 1'b1;
                        state_q <= S_LOW;
                    end else if (dcnt_q == '0) begin
                        hs_q    <= 1'b1;
                        state_q <= S_HIGH;
                    end else begin
                        dcnt_q <= dcnt_q - DT_W'(1);
                    end
                end
                S_DT_LO: begin
                    if (pwm_in) begin
                        dcnt_q  <= '0;
                        hs_q    <= 1'b1;
                        state_q <= S_HIGH;
                    end else if (dcnt_q == '0) begin
                        ls_q    <= 1'b1;
                        state_q <= S_LOW;
                    end else begin
                        dcnt_q <= dcnt_q - DT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_OFF;
                    dcnt_q  <= '0;
                    hs_q    <= 1'b0;
                    ls_q    <= 1'b0;
                end
            endcase
        end
    end

    assign hs_out      = hs_q;
    assign ls_out      = ls_q;
    assign flt_trip    = trip_q;
    assign flt_raw     = raw_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aucohl_pwm_gate_drv.sv
// Bench for aucohl_pwm_gate_drv: directed scenarios plus random traffic,
// all checked every cycle against a behavioural model of the drive rules.
module tb_aucohl_pwm_gate_drv;

  localparam int DT_W    = 8;
  localparam int FLT_LEN = 4;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            pwm_in;
  logic [DT_W-1:0] dt;
  logic            flt_in;
  logic            flt_pol;
  logic            flt_clr;
  logic            hs_out, ls_out, flt_trip, flt_raw;
  logic [2:0]      dbg_state;

  always #5 clk = ~clk;

  aucohl_pwm_gate_drv #(.DT_W(DT_W), .FLT_LEN(FLT_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pwm_in      (pwm_in),
    .dt          (dt),
    .flt_in      (flt_in),
    .flt_pol     (flt_pol),
    .flt_clr     (flt_clr),
    .hs_out      (hs_out),
    .ls_out      (ls_out),
    .flt_trip    (flt_trip),
    .flt_raw     (flt_raw),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Drive side: either off, holding a level, or waiting m_rem more edges
  // before driving m_tgt.
  bit m_hs, m_ls, m_on, m_pend, m_tgt;
  int m_rem;
  // Fault side: two-stage delay of the active-level sample and a run length.
  bit m_s1, m_s2, m_raw, m_trip;
  int m_run;

  task automatic model_drive(input bit lvl);
    m_hs = lvl;
    m_ls = !lvl;
  endtask

  task automatic model_step();
    int  run_new;
    bit  set, trip_old;
    if (rst) begin
      m_hs = 0; m_ls = 0; m_on = 0; m_pend = 0; m_tgt = 0; m_rem = 0;
      m_s1 = 0; m_s2 = 0; m_raw = 0; m_trip = 0; m_run = 0;
      return;
    end
    run_new  = m_s2 ? ((m_run < FLT_LEN) ? m_run + 1 : FLT_LEN) : 0;
    set      = (run_new == FLT_LEN);
    trip_old = m_trip;
    if (set) m_trip = 1;
    else if (flt_clr && !m_raw) m_trip = 0;
    m_raw = set;
    m_run = run_new;
    m_s2  = m_s1;
    m_s1  = (flt_in == flt_pol);

    if (!en || trip_old || set) begin
      m_hs = 0; m_ls = 0; m_on = 0; m_pend = 0;
    end else if (!m_on) begin
      m_on = 1; m_pend = 1; m_tgt = pwm_in; m_rem = int'(dt) + 1;
      m_hs = 0; m_ls = 0;
    end else if (m_pend) begin
      if (pwm_in != m_tgt) begin
        m_pend = 0;
        model_drive(pwm_in);
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_pend = 0;
          model_drive(m_tgt);
        end
      end
    end else if (pwm_in != m_hs) begin
      if (dt == 0) begin
        model_drive(pwm_in);
      end else begin
        m_hs = 0; m_ls = 0; m_pend = 1; m_tgt = pwm_in; m_rem = int'(dt);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_eq("hs_out",     hs_out,          m_hs);
    check_eq("ls_out",     ls_out,          m_ls);
    check_eq("flt_trip",   flt_trip,        m_trip);
    check_eq("flt_raw",    flt_raw,         m_raw);
    check_eq("no_overlap", hs_out & ls_out, 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Toggle pwm_in 20/20 and measure the both-low gap after every change.
  task automatic toggle_run(input int dtv, input int halves);
    int gap;
    dt = DT_W'(dtv);
    for (int h = 0; h < halves; h++) begin
      pwm_in = ~pwm_in;
      gap = 0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (!hs_out && !ls_out) gap++;
      end
      check_eq($sformatf("gap_dt%0d", dtv), gap, dtv);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs_cnt, ls_low, lat, burst_left;
    rst = 1; en = 0; pwm_in = 0; dt = 8'd3;
    flt_in = 0; flt_pol = 1; flt_clr = 0;
    steps(3);
    rst = 0;
    step();

    // dt=3 and dt=0 toggling from a settled LOW state
    en = 1; pwm_in = 0;
    steps(10);
    check_eq("settled_low", ls_out, 1);
    toggle_run(3, 4);
    toggle_run(0, 4);

    // dt=5 swallowed pulse from LOW
    dt = 8'd5; pwm_in = 0;
    steps(10);
    hs_cnt = 0; ls_low = 0;
    pwm_in = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (hs_out) hs_cnt++;
      if (!ls_out) ls_low++;
    end
    pwm_in = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (hs_out) hs_cnt++;
      if (!ls_out) ls_low++;
    end
    check_eq("swallow_hs", hs_cnt, 0);
    check_eq("swallow_ls_low", ls_low, 3);

    // fault: short glitch must not trip
    dt = 8'd3;
    flt_in = 1;
    steps(3);
    flt_in = 0;
    steps(8);
    check_eq("glitch_no_trip", flt_trip, 0);

    // fault held: trip at edge n+1+FLT_LEN
    flt_in = 1;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (flt_trip && lat == 0) lat = c;
    end
    check_eq("trip_latency", lat, FLT_LEN + 2);
    check_eq("trip_hs_off", hs_out, 0);
    check_eq("trip_ls_off", ls_out, 0);

    // clear refused while fault still present
    flt_clr = 1; step(); flt_clr = 0;
    step();
    check_eq("clr_refused", flt_trip, 1);

    // drop fault, wait, clear, then resume through a full dt gap
    flt_in = 0;
    steps(3);
    flt_clr = 1; step(); flt_clr = 0;
    check_eq("clr_accepted", flt_trip, 0);
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if ((hs_out || ls_out) && lat == 0) lat = c;
    end
    check_eq("resume_latency", lat, 3 + 2);

    // rst mid DT_HI
    dt = 8'd5; pwm_in = 0;
    steps(4);
    pwm_in = 1;
    steps(2);
    rst = 1; step(); rst = 0;
    check_eq("rst_mid_dt_trip", flt_trip, 0);
    steps(12);
    check_eq("high_before_en_drop", hs_out, 1);

    // en deasserted mid HIGH
    en = 0; step();
    check_eq("en_drop_hs", hs_out, 0);
    en = 1;
    steps(4);

    // random traffic
    burst_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1250) flt_pol = 0;
      if ($urandom_range(0, 7) == 0) pwm_in = ~pwm_in;
      if ($urandom_range(0, 31) == 0) dt = DT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 63) == 0) en = ~en;
      if (!en && $urandom_range(0, 3) == 0) en = 1;
      flt_clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      if (burst_left > 0) begin
        flt_in = flt_pol;
        burst_left--;
      end else begin
        flt_in = ~flt_pol;
        if ($urandom_range(0, 149) == 0) burst_left = $urandom_range(1, 8);
      end
      step();
    end
    rst = 0; flt_clr = 0;
    steps(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
